// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and sizes for the register-file writeback arbiter
// Ports: none (package).
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int PEND_MAX   = 3;
    // Widest writeback data the request struct can carry.
    localparam int WB_DATA_W  = 64;

    typedef logic [1:0] pend_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/wb_prio_arbiter.sv
// rtl/wb_prio_arbiter.sv - two-way MEM-priority arbiter with ALU starvation guard
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_alu_valid         ALU writeback request
//   i_mem_valid         load writeback request
//   o_alu_grant         ALU wins this cycle
//   o_mem_grant         load wins this cycle
module wb_prio_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_alu_valid,
    input  logic i_mem_valid,
    output logic o_alu_grant,
    output logic o_mem_grant
);

    logic [3:0] r_starve_cnt;
    logic       w_alu_turn;

    // After STARVE_LIMIT straight losses the ALU is owed one win.
    assign w_alu_turn = (r_starve_cnt == 4'(STARVE_LIMIT));

    always_comb begin
        o_alu_grant = i_alu_valid && (!i_mem_valid || w_alu_turn);
        o_mem_grant = i_mem_valid && !o_alu_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (i_alu_valid && !o_alu_grant) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   alu_wb_valid/ready/addr/data        ALU writeback request channel
//   mem_wb_valid/ready/addr/data        load writeback request channel
//   issue_valid/ready/addr              decode destination issue (scoreboard increment)
//   rs1_addr, rs2_addr, stall           decode source check against pending writes
//   write_en, addressC, writeBack       registered register-file write port
//   fwd1/2_hit, fwd1/2_data             write-port bypass (only with WB_FORWARD_EN)
// Config: define WB_FORWARD_EN to add the forwarding outputs and relax stall on a forwarded source.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_wb_valid,
    output logic                      alu_wb_ready,
    input  logic [REG_ADDR_W-1:0]     alu_wb_addr,
    input  logic [BUS_DATA_WIDTH-1:0] alu_wb_data,
    input  logic                      mem_wb_valid,
    output logic                      mem_wb_ready,
    input  logic [REG_ADDR_W-1:0]     mem_wb_addr,
    input  logic [BUS_DATA_WIDTH-1:0] mem_wb_data,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [REG_ADDR_W-1:0]     issue_addr,
    input  logic [REG_ADDR_W-1:0]     rs1_addr,
    input  logic [REG_ADDR_W-1:0]     rs2_addr,
    output logic                      stall,
    output logic                      write_en,
    output logic [REG_ADDR_W-1:0]     addressC,
    output logic [BUS_DATA_WIDTH-1:0] writeBack
`ifdef WB_FORWARD_EN
    ,
    output logic                      fwd1_hit,
    output logic                      fwd2_hit,
    output logic [BUS_DATA_WIDTH-1:0] fwd1_data,
    output logic [BUS_DATA_WIDTH-1:0] fwd2_data
`endif
);

    if (BUS_DATA_WIDTH > WB_DATA_W) begin : g_width_guard
        $error("BUS_DATA_WIDTH exceeds the writeback request struct width");
    end

    logic                      w_alu_grant;
    logic                      w_mem_grant;
    wb_req_t                   w_sel;
    logic                      w_issue_fire;
    logic [NUM_REGS-1:0]       w_inc_vec;
    logic [NUM_REGS-1:0]       w_dec_vec;
    logic                      w_fwd1;
    logic                      w_fwd2;

    logic                      r_write_en;
    logic [REG_ADDR_W-1:0]     r_addr_c;
    logic [BUS_DATA_WIDTH-1:0] r_wb_data;
    pend_t                     r_pend [NUM_REGS];

    wb_prio_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_alu_valid (alu_wb_valid),
        .i_mem_valid (mem_wb_valid),
        .o_alu_grant (w_alu_grant),
        .o_mem_grant (w_mem_grant)
    );

    assign alu_wb_ready = w_alu_grant;
    assign mem_wb_ready = w_mem_grant;

    always_comb begin
        w_sel = '0;
        if (w_alu_grant) begin
            w_sel.valid = 1'b1;
            w_sel.addr  = alu_wb_addr;
            w_sel.data  = WB_DATA_W'(alu_wb_data);
        end else if (w_mem_grant) begin
            w_sel.valid = 1'b1;
            w_sel.addr  = mem_wb_addr;
            w_sel.data  = WB_DATA_W'(mem_wb_data);
        end
    end

    // A grant to x0 is consumed but never reaches the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_en <= 1'b0;
            r_addr_c   <= '0;
            r_wb_data  <= '0;
        end else begin
            r_write_en <= w_sel.valid && (w_sel.addr != '0);
            if (w_sel.valid && (w_sel.addr != '0)) begin
                r_addr_c  <= w_sel.addr;
                r_wb_data <= BUS_DATA_WIDTH'(w_sel.data);
            end
        end
    end

    assign write_en  = r_write_en;
    assign addressC  = r_addr_c;
    assign writeBack = r_wb_data;

    // x0 holds pend 0 forever, so issues to x0 are always ready.
    assign issue_ready  = (r_pend[issue_addr] != pend_t'(PEND_MAX));
    assign w_issue_fire = issue_valid && issue_ready && (issue_addr != '0);

    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        if (w_issue_fire) begin
            w_inc_vec[issue_addr] = 1'b1;
        end
        if (r_write_en) begin
            w_dec_vec[r_addr_c] = 1'b1;
        end
    end

    // Simultaneous increment and decrement of one register cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_inc_vec[i] && !w_dec_vec[i]) begin
                    r_pend[i] <= r_pend[i] + 2'd1;
                end else if (!w_inc_vec[i] && w_dec_vec[i] && (r_pend[i] != '0)) begin
                    r_pend[i] <= r_pend[i] - 2'd1;
                end
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign w_fwd1    = r_write_en && (r_addr_c == rs1_addr) && (r_addr_c != '0);
    assign w_fwd2    = r_write_en && (r_addr_c == rs2_addr) && (r_addr_c != '0);
    assign fwd1_hit  = w_fwd1;
    assign fwd2_hit  = w_fwd2;
    assign fwd1_data = r_wb_data;
    assign fwd2_data = r_wb_data;
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    // A source whose only pending write is on the write port this cycle can be bypassed.
    function automatic logic src_blocked(input pend_t p, input logic fwd);
        return (p != '0) && !((p == 2'd1) && fwd);
    endfunction

    assign stall = src_blocked(r_pend[rs1_addr], w_fwd1) || src_blocked(r_pend[rs2_addr], w_fwd2);

`ifndef SYNTHESIS
    // Retiring a write to a register with nothing pending is a protocol violation.
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        r_write_en |-> (r_pend[r_addr_c] != '0));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized model-checked bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int W     = 64;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         alu_v, mem_v, issue_v;
    logic [4:0]   alu_a, mem_a, issue_a, rs1, rs2;
    logic [W-1:0] alu_d, mem_d;

    logic         alu_rdy, mem_rdy, issue_rdy, stall, write_en;
    logic [4:0]   addressC;
    logic [W-1:0] writeBack;
`ifdef WB_FORWARD_EN
    logic         fwd1_hit, fwd2_hit;
    logic [W-1:0] fwd1_data, fwd2_data;
`endif

    regfile_wb_arbiter #(
        .BUS_DATA_WIDTH (W),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_wb_valid (alu_v),
        .alu_wb_ready (alu_rdy),
        .alu_wb_addr  (alu_a),
        .alu_wb_data  (alu_d),
        .mem_wb_valid (mem_v),
        .mem_wb_ready (mem_rdy),
        .mem_wb_addr  (mem_a),
        .mem_wb_data  (mem_d),
        .issue_valid  (issue_v),
        .issue_ready  (issue_rdy),
        .issue_addr   (issue_a),
        .rs1_addr     (rs1),
        .rs2_addr     (rs2),
        .stall        (stall),
        .write_en     (write_en),
        .addressC     (addressC),
        .writeBack    (writeBack)
`ifdef WB_FORWARD_EN
        ,
        .fwd1_hit     (fwd1_hit),
        .fwd2_hit     (fwd2_hit),
        .fwd1_data    (fwd1_data),
        .fwd2_data    (fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: outstanding writes per register, ALU loss streak, the write in flight.
    int           m_pend [32];
    int           m_starve;
    bit           m_we;
    int           m_addr;
    logic [W-1:0] m_data;
    int           pool[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_alu_grant();
        return alu_v && (!mem_v || m_starve == LIMIT);
    endfunction

    function automatic bit m_mem_grant();
        return mem_v && !m_alu_grant();
    endfunction

    function automatic bit m_hit(input int rs);
`ifdef WB_FORWARD_EN
        return m_we && m_addr == rs && m_addr != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_blocked(input int rs);
        return m_pend[rs] != 0 && !(m_pend[rs] == 1 && m_hit(rs));
    endfunction

    task automatic settle();
        #1;
        chk("alu_ready", alu_rdy, m_alu_grant());
        chk("mem_ready", mem_rdy, m_mem_grant());
        chk("issue_ready", issue_rdy, m_pend[issue_a] != 3);
        chk("stall", stall, m_blocked(rs1) || m_blocked(rs2));
        chk("write_en", write_en, m_we);
        if (m_we) begin
            chk("addressC", addressC, m_addr);
            chk("writeBack", writeBack, m_data);
        end
`ifdef WB_FORWARD_EN
        chk("fwd1_hit", fwd1_hit, m_hit(rs1));
        chk("fwd2_hit", fwd2_hit, m_hit(rs2));
        if (m_we) chk("fwd1_data", fwd1_data, m_data);
`endif
    endtask

    task automatic advance();
        bit ag, mg, inc;
        @(posedge clk);
        ag = m_alu_grant();
        mg = m_mem_grant();
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_starve = 0;
            m_we     = 0;
            m_addr   = 0;
            m_data   = '0;
            pool.delete();
            ag = 0;
            mg = 0;
        end else begin
            inc = issue_v && issue_a != 0 && m_pend[issue_a] != 3;
            if (!(inc && m_we && issue_a == m_addr)) begin
                if (inc) m_pend[issue_a]++;
                if (m_we && m_pend[m_addr] > 0) m_pend[m_addr]--;
            end
            if (inc) pool.push_back(int'(issue_a));
            m_starve = (alu_v && !ag) ? m_starve + 1 : 0;
            m_we = 0;
            if (ag && alu_a != 0) begin
                m_we = 1; m_addr = alu_a; m_data = alu_d;
            end else if (mg && mem_a != 0) begin
                m_we = 1; m_addr = mem_a; m_data = mem_d;
            end
        end
        @(negedge clk);
        if (ag) alu_v = 1'b0;
        if (mg) mem_v = 1'b0;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic issue(input int r);
        issue_v = 1'b1;
        issue_a = 5'(r);
        tick();
        issue_v = 1'b0;
    endtask

    initial begin
        int idx;
        reset = 1'b1;
        alu_v = 0; mem_v = 0; issue_v = 0;
        alu_a = 0; mem_a = 0; issue_a = 0; rs1 = 0; rs2 = 0;
        alu_d = '0; mem_d = '0;
        @(negedge clk);
        advance();
        advance();

        // Reset state
        reset = 1'b0;
        settle();
        chk("rst_write_en", write_en, 0);
        chk("rst_addressC", addressC, 0);
        chk("rst_writeBack", writeBack, 0);
        chk("rst_stall", stall, 0);
        advance();

        // Single ALU write to r5
        issue(5);
        alu_v = 1; alu_a = 5; alu_d = 64'hAB; rs1 = 5;
        settle();
        chk("single_alu_ready", alu_rdy, 1);
        chk("single_stall_pending", stall, 1);
        advance();
        settle();
        chk("single_we", write_en, 1);
        chk("single_addr", addressC, 5);
        chk("single_data", writeBack, 64'hAB);
        advance();
        settle();
        chk("single_stall_cleared", stall, 0);
        advance();
        rs1 = 0;

        // Starvation pattern: MEM x4 then ALU, repeating
        for (int r = 10; r <= 13; r++) for (int k = 0; k < 3; k++) issue(r);
        for (int c = 0; c < 10; c++) begin
            alu_v = 1; alu_a = 10; alu_d = 64'(c);
            mem_v = 1; mem_a = 5'(11 + c % 3); mem_d = 64'(100 + c);
            settle();
            chk("starve_alu_grant", alu_rdy, (c % 5) == 4);
            chk("starve_mem_grant", mem_rdy, (c % 5) != 4);
            if (c > 0) chk("starve_we_every_cycle", write_en, 1);
            advance();
        end
        alu_v = 0; mem_v = 0;
        tick();

        // r7 counter saturation and stall release
        rs1 = 7;
        issue(7);
        issue(7);
        settle();
        chk("r7_stall_two", stall, 1);
        advance();
        issue(7);
        issue_v = 1; issue_a = 7;
        settle();
        chk("r7_issue_saturated", issue_rdy, 0);
        advance();
        issue_v = 0;
        for (int k = 0; k < 3; k++) begin
            mem_v = 1; mem_a = 7; mem_d = 64'(k);
            tick();
        end
        settle();
        chk("r7_stall_last_strobe", stall, 1);
        advance();
        settle();
        chk("r7_stall_released", stall, 0);
        advance();

        // Issue and retire of r3 on the same edge
        rs1 = 3;
        issue(3);
        mem_v = 1; mem_a = 3; mem_d = 64'h33;
        tick();
        issue_v = 1; issue_a = 3;
        settle();
        chk("r3_strobe", write_en, 1);
        advance();
        issue_v = 0;
        settle();
        chk("r3_pend_kept", stall, 1);
        advance();

        // ALU write to x0
        alu_v = 1; alu_a = 0; alu_d = 64'hDEAD;
        settle();
        chk("x0_ready", alu_rdy, 1);
        advance();
        settle();
        chk("x0_no_write", write_en, 0);
        advance();

`ifdef WB_FORWARD_EN
        rs1 = 0; rs2 = 9;
        issue(9);
        mem_v = 1; mem_a = 9; mem_d = 64'h9999;
        tick();
        settle();
        chk("fwd2_hit_lit", fwd2_hit, 1);
        chk("fwd2_data_lit", fwd2_data, 64'h9999);
        chk("fwd_stall_lit", stall, 0);
        advance();
`endif

        // Reset with both requesters valid and pend nonzero
        rs1 = 3; rs2 = 7;
        alu_v = 1; alu_a = 0; mem_v = 1; mem_a = 0;
        issue_v = 1; issue_a = 4;
        reset = 1;
        tick();
        reset = 0; issue_v = 0;
        settle();
        chk("post_rst_we", write_en, 0);
        chk("post_rst_mem_ready", mem_rdy, 1);
        chk("post_rst_alu_ready", alu_rdy, 0);
        chk("post_rst_stall", stall, 0);
        advance();
        alu_v = 0; mem_v = 0;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!alu_v && $urandom_range(2) == 0) begin
                alu_a = 0;
                if (pool.size() > 0 && $urandom_range(7) != 0) begin
                    idx = $urandom_range(pool.size() - 1);
                    alu_a = 5'(pool[idx]);
                    pool.delete(idx);
                end
                alu_d = {$urandom, $urandom};
                alu_v = 1;
            end
            if (!mem_v && $urandom_range(2) == 0) begin
                mem_a = 0;
                if (pool.size() > 0 && $urandom_range(7) != 0) begin
                    idx = $urandom_range(pool.size() - 1);
                    mem_a = 5'(pool[idx]);
                    pool.delete(idx);
                end
                mem_d = {$urandom, $urandom};
                mem_v = 1;
            end
            issue_v = 1'($urandom_range(1));
            issue_a = 5'($urandom_range(7));
            rs1     = 5'($urandom_range(7));
            rs2     = 5'($urandom_range(9));
            reset   = ($urandom_range(299) == 0);
            tick();
            if (reset) begin
                reset = 0;
                alu_v = 0;
                mem_v = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
